uart_echo_checker: RTL and testbench

Initiator-side counterpart of the board's UART echo path. It sends a run of pattern bytes through the existing `uart_tx`, waits for each byte to come back through `uart_rx`, and compares each returned byte against what was sent. It reports a pass/fail verdict, a mismatch count and a timeout flag. It sits in the test/bring-up top next to the `uart_tx` and `uart_rx` instances and replaces the echo glue when the board is driving a remote mirror.

---
 rtl/uart_echo_checker_pkg.sv | 30 +++
 rtl/uart_echo_checker_timer.sv | 36 +++
 rtl/uart_echo_checker.sv | 195 +++++++++++++++++++
 tb/tb_uart_echo_checker.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_echo_checker_pkg.sv
// uart_echo_checker_pkg
//   Shared definitions for the UART echo checker: default line settings,
//   the bit-period helper, the checker FSM state type and a saturating
//   error-count adder.
package uart_echo_checker_pkg;

    localparam int unsigned DEF_CLK_FREQ = 12_000_000;
    localparam int unsigned DEF_BAUD     = 115_200;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_ECHO = 3'd2,
        ST_CHECK     = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    // Clock cycles per UART bit (integer division).
    function automatic int unsigned uart_bit_cyc(input int unsigned f, input int unsigned b);
        return f / b;
    endfunction

    // 8-bit add of a small increment, clamped at 255.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
        logic [8:0] s;
        s = {1'b0, a} + {7'b0, inc};
        return s[8] ? '1 : s[7:0];
    endfunction

endpackage

// File: rtl/uart_echo_checker_timer.sv
// byte_timer
//   Clearable up-counter that stops at LIMIT and flags it on hit.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     clr      : synchronous clear to zero (wins over en)
//     en       : count enable
//     hit      : high while the count equals LIMIT
module byte_timer
    import uart_echo_checker_pkg::*;
#(
    parameter int unsigned LIMIT = 4160
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam int unsigned W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    assign hit = (cnt == W'(LIMIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !hit) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_echo_checker.sv
// uart_echo_checker
//   Sends SEED, SEED+1, ... (count bytes, 0 = 256) through an external
//   uart_tx, waits for each echo from an external uart_rx and compares it.
//   Reports pass/fail, a saturating mismatch count and a sticky timeout.
//   Ports:
//     clk, rst            : clock, asynchronous active-high reset
//     start, count        : run request (IDLE only) and bytes per run
//     tx_start, tx_data   : request/byte to uart_tx; tx_busy from uart_tx
//     rx_ready, rx_data   : echoed byte strobe/data from uart_rx
//     busy, done          : run in progress / one-cycle end-of-run pulse
//     pass, err_count     : verdict (valid from done), mismatch count
//     timeout_err         : sticky echo-timeout flag
module uart_echo_checker
    import uart_echo_checker_pkg::*;
#(
    parameter int unsigned CLK_FREQ      = DEF_CLK_FREQ,
    parameter int unsigned BAUD          = DEF_BAUD,
    parameter logic [7:0]  SEED          = 8'hA5,
    parameter int unsigned TIMEOUT_BYTES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] count,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    input  logic       rx_ready,
    input  logic [7:0] rx_data,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic       timeout_err
);

    localparam int unsigned TIMEOUT_CYC = uart_bit_cyc(CLK_FREQ, BAUD) * 10 * TIMEOUT_BYTES;

    state_t     state, state_n;
    logic [7:0] idx, idx_n;
    logic [7:0] last_idx, last_idx_n;
    logic [7:0] rx_byte, rx_byte_n;
    logic [7:0] pend_byte, pend_byte_n;
    logic       pend, pend_n;
    logic       tx_start_n;
    logic [7:0] tx_data_n;
    logic [7:0] err_n;
    logic       tout_n, pass_n;
    logic       clear_err;
    logic [1:0] err_inc;
    logic       tmr_clr, tmr_en, tmr_hit;
    logic [7:0] pattern;

    assign pattern = SEED + idx;
    assign busy    = (state inside {ST_SEND, ST_WAIT_ECHO, ST_CHECK});
    assign done    = (state == ST_DONE);

    byte_timer #(
        .LIMIT(TIMEOUT_CYC)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (tmr_clr),
        .en  (tmr_en),
        .hit (tmr_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        last_idx_n  = last_idx;
        rx_byte_n   = rx_byte;
        pend_n      = pend;
        pend_byte_n = pend_byte;
        tx_start_n  = 1'b0;
        tx_data_n   = tx_data;
        tout_n      = timeout_err;
        pass_n      = pass;
        clear_err   = 1'b0;
        err_inc     = '0;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n    = ST_SEND;
                    last_idx_n = count - 8'd1;   // count 0 wraps to 255 -> 256 bytes
                    idx_n      = '0;
                    clear_err  = 1'b1;
                    tout_n     = 1'b0;
                    pass_n     = 1'b0;
                    pend_n     = 1'b0;
                    tx_start_n = !tx_busy;
                    tx_data_n  = SEED;
                end
            end
            ST_SEND: begin
                // Only leave once our own request has been taken; a tx_busy
                // seen before the request went out just delays the send.
                if (tx_start && tx_busy) begin
                    state_n = ST_WAIT_ECHO;
                    tmr_clr = 1'b1;
                end else begin
                    tx_start_n = !tx_busy;
                end
            end
            ST_WAIT_ECHO: begin
                tmr_en = 1'b1;
                if (pend) begin
                    rx_byte_n = pend_byte;
                    pend_n    = 1'b0;
                    state_n   = ST_CHECK;
                end else if (rx_ready) begin
                    rx_byte_n = rx_data;
                    state_n   = ST_CHECK;
                end else if (tmr_hit) begin
                    tout_n  = 1'b1;
                    err_inc = 2'd1;
                    state_n = ST_DONE;
                end
            end
            ST_CHECK: begin
                if (rx_byte != pattern) begin
                    err_inc = 2'd1;
                end
                if (idx == last_idx) begin
                    state_n = ST_DONE;
                end else begin
                    idx_n      = idx + 8'd1;
                    state_n    = ST_SEND;
                    tx_start_n = !tx_busy;
                    tx_data_n  = SEED + idx + 8'd1;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Early echoes park in a one-deep latch; a strobe arriving while the
        // latch is full is dropped and counted as a mismatch.
        if (rx_ready && pend && (state inside {ST_SEND, ST_WAIT_ECHO, ST_CHECK})) begin
            err_inc = err_inc + 2'd1;
        end else if (rx_ready && (state inside {ST_SEND, ST_CHECK})) begin
            pend_n      = 1'b1;
            pend_byte_n = rx_data;
        end

        err_n = clear_err ? '0 : sat_add8(err_count, err_inc);

        // Verdict is registered on entry to DONE so it is valid with done.
        if (state_n == ST_DONE) begin
            pass_n = (err_n == '0) && !tout_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx         <= '0;
            last_idx    <= '0;
            rx_byte     <= '0;
            pend        <= 1'b0;
            pend_byte   <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            err_count   <= '0;
            timeout_err <= 1'b0;
            pass        <= 1'b0;
        end else begin
            idx         <= idx_n;
            last_idx    <= last_idx_n;
            rx_byte     <= rx_byte_n;
            pend        <= pend_n;
            pend_byte   <= pend_byte_n;
            tx_start    <= tx_start_n;
            tx_data     <= tx_data_n;
            err_count   <= err_n;
            timeout_err <= tout_n;
            pass        <= pass_n;
        end
    end

endmodule

// File: tb/tb_uart_echo_checker.sv
// Bench for uart_echo_checker: a behavioural mirror per instance echoes
// each transmitted byte after BT cycles, optionally corrupting or dropping
// one byte; channel 0 can also be driven by hand.
module tb_uart_echo_checker;

    localparam int BT = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    logic       a_start = 1'b0, a_tx_start, a_tx_busy, a_rx_ready, a_busy, a_done, a_pass, a_tout;
    logic [7:0] a_count = 8'd0, a_tx_data, a_rx_data, a_err;
    logic       b_start = 1'b0, b_tx_start, b_tx_busy, b_rx_ready, b_busy, b_done, b_pass, b_tout;
    logic [7:0] b_count = 8'd0, b_tx_data, b_rx_data, b_err;

    logic       man_mode = 1'b0, man_busy = 1'b0, man_rdy = 1'b0;
    logic [7:0] man_rdata = 8'd0;

    logic       mir_busy[2]  = '{1'b0, 1'b0};
    logic       mir_rdy[2]   = '{1'b0, 1'b0};
    logic [7:0] mir_rdata[2] = '{8'd0, 8'd0};
    logic [7:0] mir_byte[2]  = '{8'd0, 8'd0};
    int         mir_cnt[2]   = '{0, 0};
    int         mir_idx[2]   = '{0, 0};
    int         flip_idx[2]  = '{-1, -1};
    int         drop_idx[2]  = '{-1, -1};
    int         sent_n[2]    = '{0, 0};
    logic [7:0] sent_mem[2][512];
    logic       m_ts;
    logic [7:0] m_td;

    assign a_tx_busy  = man_mode ? man_busy  : mir_busy[0];
    assign a_rx_ready = man_mode ? man_rdy   : mir_rdy[0];
    assign a_rx_data  = man_mode ? man_rdata : mir_rdata[0];
    assign b_tx_busy  = mir_busy[1];
    assign b_rx_ready = mir_rdy[1];
    assign b_rx_data  = mir_rdata[1];

    uart_echo_checker dut (
        .clk(clk), .rst(rst), .start(a_start), .count(a_count),
        .tx_start(a_tx_start), .tx_data(a_tx_data), .tx_busy(a_tx_busy),
        .rx_ready(a_rx_ready), .rx_data(a_rx_data),
        .busy(a_busy), .done(a_done), .pass(a_pass),
        .err_count(a_err), .timeout_err(a_tout)
    );

    uart_echo_checker #(.SEED(8'hFF)) dut_ff (
        .clk(clk), .rst(rst), .start(b_start), .count(b_count),
        .tx_start(b_tx_start), .tx_data(b_tx_data), .tx_busy(b_tx_busy),
        .rx_ready(b_rx_ready), .rx_data(b_rx_data),
        .busy(b_busy), .done(b_done), .pass(b_pass),
        .err_count(b_err), .timeout_err(b_tout)
    );

    initial forever #5 clk = ~clk;

    // Mirror: accept tx_start, stay busy BT cycles, then echo (maybe altered).
    initial forever begin
        @(negedge clk or posedge rst);
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                mir_busy[g] = 1'b0;
                mir_rdy[g]  = 1'b0;
                mir_cnt[g]  = 0;
            end else if (!(g == 0 && man_mode)) begin
                m_ts = (g == 0) ? a_tx_start : b_tx_start;
                m_td = (g == 0) ? a_tx_data  : b_tx_data;
                mir_rdy[g] = 1'b0;
                if (mir_busy[g]) begin
                    if (mir_cnt[g] > 1) begin
                        mir_cnt[g] = mir_cnt[g] - 1;
                    end else begin
                        mir_busy[g] = 1'b0;
                        if (mir_idx[g] != drop_idx[g]) begin
                            mir_rdy[g]   = 1'b1;
                            mir_rdata[g] = (mir_idx[g] == flip_idx[g]) ? (mir_byte[g] ^ 8'h01) : mir_byte[g];
                        end
                    end
                end else if (m_ts) begin
                    mir_busy[g] = 1'b1;
                    mir_cnt[g]  = BT;
                    mir_byte[g] = m_td;
                    mir_idx[g]  = sent_n[g];
                    sent_mem[g][sent_n[g] % 512] = m_td;
                    sent_n[g] = sent_n[g] + 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input int ch, input int poke, output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        while (!ok && cyc < 12000) begin
            a_start = (poke > 0 && cyc == poke);
            if (a_start) a_count = 8'd1;
            @(negedge clk);
            cyc++;
            ok = (ch == 0) ? a_done : b_done;
        end
        a_start = 1'b0;
    endtask

    task automatic run(input int ch, input logic [7:0] n, input int poke,
                       output bit ok, output int cyc, output logic b1, output logic t1);
        @(negedge clk);
        if (ch == 0) begin a_count = n; a_start = 1'b1; end
        else         begin b_count = n; b_start = 1'b1; end
        @(negedge clk);
        a_start = 1'b0;
        b_start = 1'b0;
        b1 = (ch == 0) ? a_busy : b_busy;
        t1 = (ch == 0) ? a_tx_start : b_tx_start;
        wait_done(ch, poke, ok, cyc);
        cyc++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=no_finish want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit   ok;
        int   cyc, base, nbad;
        logic b1, t1;

        repeat (3) @(negedge clk);
        chk("rst_busy",     32'(a_busy),     32'd0);
        chk("rst_done",     32'(a_done),     32'd0);
        chk("rst_pass",     32'(a_pass),     32'd0);
        chk("rst_err",      32'(a_err),      32'd0);
        chk("rst_tout",     32'(a_tout),     32'd0);
        chk("rst_tx_start", 32'(a_tx_start), 32'd0);
        chk("rst_tx_data",  32'(a_tx_data),  32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Clean loopback, count=4
        base = sent_n[0];
        run(0, 8'd4, 0, ok, cyc, b1, t1);
        chk("clean_done",   32'(ok),   32'd1);
        chk("clean_busy1",  32'(b1),   32'd1);
        chk("clean_txs1",   32'(t1),   32'd1);
        chk("clean_pass",   32'(a_pass), 32'd1);
        chk("clean_err",    32'(a_err),  32'd0);
        chk("clean_tout",   32'(a_tout), 32'd0);
        chk("clean_busy_at_done", 32'(a_busy), 32'd0);
        chk("clean_nsent",  32'(sent_n[0] - base), 32'd4);
        chk("clean_b0", 32'(sent_mem[0][base]),     32'hA5);
        chk("clean_b1", 32'(sent_mem[0][base + 1]), 32'hA6);
        chk("clean_b2", 32'(sent_mem[0][base + 2]), 32'hA7);
        chk("clean_b3", 32'(sent_mem[0][base + 3]), 32'hA8);
        @(negedge clk);
        chk("pass_held", 32'(a_pass), 32'd1);
        chk("done_pulse", 32'(a_done), 32'd0);

        // Corruption of 2nd byte, count=3
        base = sent_n[0];
        flip_idx[0] = base + 1;
        run(0, 8'd3, 0, ok, cyc, b1, t1);
        flip_idx[0] = -1;
        chk("corr_done",  32'(ok),     32'd1);
        chk("corr_err",   32'(a_err),  32'd1);
        chk("corr_pass",  32'(a_pass), 32'd0);
        chk("corr_tout",  32'(a_tout), 32'd0);
        chk("corr_nsent", 32'(sent_n[0] - base), 32'd3);

        // Timeout: 2nd echo dropped, count=5
        base = sent_n[0];
        drop_idx[0] = base + 1;
        run(0, 8'd5, 0, ok, cyc, b1, t1);
        drop_idx[0] = -1;
        chk("tout_done",  32'(ok),     32'd1);
        chk("tout_flag",  32'(a_tout), 32'd1);
        chk("tout_err",   32'(a_err),  32'd1);
        chk("tout_pass",  32'(a_pass), 32'd0);
        chk("tout_nsent", 32'(sent_n[0] - base), 32'd2);
        chk("tout_long",  32'(cyc > 4160), 32'd1);

        // Wrap with SEED=FF, count=0 -> 256 bytes
        base = sent_n[1];
        run(1, 8'd0, 0, ok, cyc, b1, t1);
        chk("wrap_done",  32'(ok),     32'd1);
        chk("wrap_pass",  32'(b_pass), 32'd1);
        chk("wrap_err",   32'(b_err),  32'd0);
        chk("wrap_nsent", 32'(sent_n[1] - base), 32'd256);
        chk("wrap_b0",    32'(sent_mem[1][base]),       32'hFF);
        chk("wrap_b1",    32'(sent_mem[1][base + 1]),   32'h00);
        chk("wrap_b255",  32'(sent_mem[1][base + 255]), 32'hFE);
        nbad = 0;
        for (int i = 0; i < 256; i++) begin
            if (sent_mem[1][(base + i) % 512] != 8'((i + 255) % 256)) nbad++;
        end
        chk("wrap_all", 32'(nbad), 32'd0);

        // Start pulse mid-run is ignored, count=3
        base = sent_n[0];
        run(0, 8'd3, 5, ok, cyc, b1, t1);
        chk("ign_done",  32'(ok),     32'd1);
        chk("ign_pass",  32'(a_pass), 32'd1);
        chk("ign_nsent", 32'(sent_n[0] - base), 32'd3);
        chk("ign_b2",    32'(sent_mem[0][base + 2]), 32'hA7);

        // Early echo in SEND then a second strobe (0x00), count=1
        man_mode = 1'b1; man_busy = 1'b0; man_rdy = 1'b0;
        @(negedge clk); a_count = 8'd1; a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        chk("early_txs", 32'(a_tx_start), 32'd1);
        man_rdy = 1'b1; man_rdata = 8'hA5;
        @(negedge clk); man_rdata = 8'h00;
        @(negedge clk); man_rdy = 1'b0; man_busy = 1'b1;
        @(negedge clk); man_busy = 1'b0;
        chk("early_txs_drop", 32'(a_tx_start), 32'd0);
        wait_done(0, 0, ok, cyc);
        chk("early_done", 32'(ok),     32'd1);
        chk("early_err",  32'(a_err),  32'd1);
        chk("early_pass", 32'(a_pass), 32'd0);
        chk("early_tout", 32'(a_tout), 32'd0);

        // Reset while tx_start is asserted in SEND
        @(negedge clk); a_count = 8'd2; a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        chk("rsts_txs_pre", 32'(a_tx_start), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rsts_txs",  32'(a_tx_start), 32'd0);
        chk("rsts_busy", 32'(a_busy),     32'd0);
        @(negedge clk); rst = 1'b0;

        // rx_ready in IDLE must not disturb the next run
        man_rdy = 1'b1; man_rdata = 8'h3C;
        @(negedge clk); man_rdy = 1'b0;
        @(negedge clk); man_mode = 1'b0;
        run(0, 8'd2, 0, ok, cyc, b1, t1);
        chk("idle_rx_done", 32'(ok),     32'd1);
        chk("idle_rx_pass", 32'(a_pass), 32'd1);
        chk("idle_rx_err",  32'(a_err),  32'd0);

        // Reset in WAIT_ECHO with err_count already 1
        base = sent_n[0];
        flip_idx[0] = base;
        drop_idx[0] = base + 1;
        @(negedge clk); a_count = 8'd3; a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        cyc = 0;
        while (a_err != 8'd1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        repeat (BT + 10) @(negedge clk);
        chk("rstw_err_pre",  32'(a_err),  32'd1);
        chk("rstw_busy_pre", 32'(a_busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstw_busy", 32'(a_busy),     32'd0);
        chk("rstw_txs",  32'(a_tx_start), 32'd0);
        chk("rstw_err",  32'(a_err),      32'd0);
        chk("rstw_tout", 32'(a_tout),     32'd0);
        chk("rstw_done", 32'(a_done),     32'd0);
        flip_idx[0] = -1;
        drop_idx[0] = -1;
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
